// File: rtl/iod_rd_train_ctrl.sv
// Read-training sequencer for one DDR3 byte lane: sweeps the IOD delay line,
// finds the longest passing eye window and centres on it. Optional: IOD_RD_TRAIN_RETRY_EN.
module iod_rd_train_ctrl #(
  parameter int unsigned TAP_MAX       = 127,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SAMPLE_CYCLES = 16
) (
  input  logic       FAB_CLK,
  input  logic       ARST_N,
  input  logic       START,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAIL,
  output logic [7:0] TAP_OUT,
  output logic [7:0] WIN_START,
  output logic [7:0] WIN_LEN,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP, S_CENTER, S_FIN
  } state_t;

  state_t     state_q;
  logic       busy_q, done_q, fail_q, load_q, move_q, dir_q, clear_q, bad_q;
  logic [7:0] tap_out_q, win_start_q, win_len_q;
  logic [7:0] tap_q, cnt_q, cur_start_q, cur_len_q, best_start_q, best_len_q;
  logic [7:0] cur_start_d, cur_len_d, target;
  logic       best_upd;
`ifdef IOD_RD_TRAIN_RETRY_EN
  logic       retry_q;
`endif

  always_comb begin
    cur_start_d = cur_start_q;
    cur_len_d   = cur_len_q;
    if (!bad_q) begin
      if (cur_len_q == '0) cur_start_d = tap_q;
      if (cur_len_q != '1) cur_len_d = cur_len_q + 8'd1;
    end else begin
      cur_len_d = '0;
    end
    best_upd = (cur_len_d > best_len_q);
    // 8-bit modular sum equals the 9-bit sum truncated to 8 bits
    target   = best_start_q + ((best_len_q - 8'd1) >> 1);
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      load_q       <= 1'b0;
      move_q       <= 1'b0;
      dir_q        <= 1'b1;
      clear_q      <= 1'b0;
      bad_q        <= 1'b0;
      tap_out_q    <= '0;
      win_start_q  <= '0;
      win_len_q    <= '0;
      tap_q        <= '0;
      cnt_q        <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
`ifdef IOD_RD_TRAIN_RETRY_EN
      retry_q      <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      move_q  <= 1'b0;
      clear_q <= 1'b0;
      case (state_q)
        S_IDLE: if (START) begin
          busy_q       <= 1'b1;
          fail_q       <= 1'b0;
          win_start_q  <= '0;
          win_len_q    <= '0;
          tap_q        <= '0;
          cur_start_q  <= '0;
          cur_len_q    <= '0;
          best_start_q <= '0;
          best_len_q   <= '0;
          dir_q        <= 1'b1;
          load_q       <= 1'b1;
`ifdef IOD_RD_TRAIN_RETRY_EN
          retry_q      <= 1'b0;
`endif
          state_q      <= S_LOAD;
        end
        S_LOAD: begin
          tap_q   <= '0;
          clear_q <= 1'b1;
          state_q <= S_CLEAR;
        end
        S_CLEAR: begin
          cnt_q   <= '0;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            state_q <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_SAMPLE: begin
          bad_q <= bad_q | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
          if (cnt_q == 8'(SAMPLE_CYCLES - 1)) state_q <= S_EVAL;
          else cnt_q <= cnt_q + 8'd1;
        end
        S_EVAL: begin
          cur_start_q <= cur_start_d;
          cur_len_q   <= cur_len_d;
          if (best_upd) begin
            best_start_q <= cur_start_d;
            best_len_q   <= cur_len_d;
          end
          if (tap_q == 8'(TAP_MAX) || DELAY_LINE_OUT_OF_RANGE) begin
            dir_q   <= 1'b0;
            state_q <= S_CENTER;
          end else begin
            move_q  <= 1'b1;
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          tap_q   <= tap_q + 8'd1;
          clear_q <= 1'b1;
          state_q <= S_CLEAR;
        end
        S_CENTER: begin
          if (best_len_q == '0) begin
`ifdef IOD_RD_TRAIN_RETRY_EN
            if (!retry_q) begin
              retry_q     <= 1'b1;
              cur_start_q <= '0;
              cur_len_q   <= '0;
              dir_q       <= 1'b1;
              load_q      <= 1'b1;
              state_q     <= S_LOAD;
            end else begin
              fail_q      <= 1'b1;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              tap_out_q   <= tap_q;
              win_start_q <= best_start_q;
              win_len_q   <= best_len_q;
              state_q     <= S_FIN;
            end
`else
            fail_q      <= 1'b1;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            tap_out_q   <= tap_q;
            win_start_q <= best_start_q;
            win_len_q   <= best_len_q;
            state_q     <= S_FIN;
`endif
          end else if (move_q) begin
            // idle gap after each backward pulse
          end else if (tap_q > target) begin
            move_q <= 1'b1;
            tap_q  <= tap_q - 8'd1;
          end else begin
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            tap_out_q   <= tap_q;
            win_start_q <= best_start_q;
            win_len_q   <= best_len_q;
            state_q     <= S_FIN;
          end
        end
        S_FIN: begin
          dir_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BUSY                    = busy_q;
  assign DONE                    = done_q;
  assign FAIL                    = fail_q;
  assign TAP_OUT                 = tap_out_q;
  assign WIN_START               = win_start_q;
  assign WIN_LEN                 = win_len_q;
  assign DELAY_LINE_LOAD         = load_q;
  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_q;

endmodule

// File: tb/tb_iod_rd_train_ctrl.sv
// Bench for iod_rd_train_ctrl: a delay-line/eye model drives flags from a pass map,
// and each run is compared against a window search done directly on that map.
module tb_iod_rd_train_ctrl;
  localparam int TAPM = 127;
  localparam int SET  = 4;
  localparam int SAM  = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, fail;
  logic [7:0] tap_out, win_start, win_len;
  logic       dl_load, dl_move, dl_dir, dl_oor;
  logic       em_clear, em_early, em_late;

  always #5 clk = ~clk;

  iod_rd_train_ctrl #(.TAP_MAX(TAPM), .SETTLE_CYCLES(SET), .SAMPLE_CYCLES(SAM)) dut (
    .FAB_CLK(clk), .ARST_N(rst_n), .START(start),
    .BUSY(busy), .DONE(done), .FAIL(fail),
    .TAP_OUT(tap_out), .WIN_START(win_start), .WIN_LEN(win_len),
    .DELAY_LINE_LOAD(dl_load), .DELAY_LINE_MOVE(dl_move),
    .DELAY_LINE_DIRECTION(dl_dir), .DELAY_LINE_OUT_OF_RANGE(dl_oor),
    .EYE_MONITOR_CLEAR_FLAGS(em_clear),
    .EYE_MONITOR_EARLY(em_early), .EYE_MONITOR_LATE(em_late)
  );

  int n_chk = 0, n_pass = 0;
  bit pass_map [0:255];
  int oor_tap = 256;
  int dl_tap = 0;
  int n_load, n_inc, n_dec, n_clr, n_done, n_busy, dir_viol;
  logic prev_dir = 1'b1, prev_move = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_counts();
    n_load = 0; n_inc = 0; n_dec = 0; n_clr = 0; n_done = 0; n_busy = 0; dir_viol = 0;
  endtask

  // Delay-line and eye-monitor plant
  always @(negedge clk) begin
    int r;
    if (dl_load) begin n_load++; dl_tap = 0; end
    if (dl_move) begin
      if (dl_dir) begin n_inc++; dl_tap++; end
      else begin n_dec++; dl_tap--; end
    end
    if (em_clear) n_clr++;
    if (done) n_done++;
    if (busy) n_busy++;
    if (dl_dir !== prev_dir && (dl_move || prev_move)) dir_viol++;
    prev_dir  = dl_dir;
    prev_move = dl_move;
    dl_oor = (dl_tap >= oor_tap);
    if (dl_tap < 0 || dl_tap > 255 || !pass_map[dl_tap]) begin
      r = $urandom_range(1, 3);
      em_early = r[0];
      em_late  = r[1];
    end else begin
      // a passing tap may still show a stale flag coincident with the clear strobe
      r = $urandom_range(0, 3);
      em_early = em_clear & r[0];
      em_late  = em_clear & r[1];
    end
  end

  task automatic clear_map();
    for (int i = 0; i < 256; i++) pass_map[i] = 1'b0;
    oor_tap = 256;
  endtask

  task automatic set_win(input int s, input int l);
    for (int i = s; i < s + l && i < 256; i++) pass_map[i] = 1'b1;
  endtask

  task automatic model(output int e_end, output int e_ws, output int e_wl,
                       output int e_tap, output int e_fail, output int e_dec);
    int s, l;
    e_end = (oor_tap < TAPM) ? oor_tap : TAPM;
    e_ws = 0; e_wl = 0; s = 0;
    while (s <= e_end) begin
      if (pass_map[s]) begin
        l = 0;
        while (s + l <= e_end && pass_map[s + l]) l++;
        if (l > e_wl) begin e_wl = l; e_ws = s; end
        s += l;
      end else s++;
    end
    e_fail = (e_wl == 0);
    e_tap  = e_fail ? e_end : e_ws + (e_wl - 1) / 2;
    e_dec  = e_fail ? 0 : e_end - e_tap;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk); #1;
      if (done) seen = 1'b1;
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_results(input string tag);
    int e_end, e_ws, e_wl, e_tap, e_fail, e_dec, sweep, e_busy, e_load, e_inc;
    model(e_end, e_ws, e_wl, e_tap, e_fail, e_dec);
    sweep  = e_end * (SET + SAM + 3) + (SET + SAM + 2);
    e_busy = 1 + sweep + 1 + 2 * e_dec;
    e_load = 1;
    e_inc  = e_end;
`ifdef IOD_RD_TRAIN_RETRY_EN
    if (e_fail != 0) begin
      e_busy = 2 * (2 + sweep);
      e_load = 2;
      e_inc  = 2 * e_end;
    end
`endif
    check({tag, "_tap_out"},   int'(tap_out),   e_tap);
    check({tag, "_win_start"}, int'(win_start), e_ws);
    check({tag, "_win_len"},   int'(win_len),   e_wl);
    check({tag, "_fail"},      int'(fail),      e_fail);
    check({tag, "_busy_low"},  int'(busy),      0);
    check({tag, "_inc_moves"}, n_inc,           e_inc);
    check({tag, "_dec_moves"}, n_dec,           e_dec);
    check({tag, "_loads"},     n_load,          e_load);
    check({tag, "_busy_cyc"},  n_busy,          e_busy);
    check({tag, "_dl_pos"},    dl_tap,          e_tap);
    check({tag, "_dir_stable"}, dir_viol,       0);
  endtask

  task automatic run(input string tag, input bit hold);
    clear_counts();
    @(negedge clk); start = 1'b1;
    if (!hold) begin @(negedge clk); start = 1'b0; end
    wait_done(tag);
    check_results(tag);
    if (hold) begin
      @(negedge clk); #1;
      check({tag, "_gap_busy"}, int'(busy), 0);
      check({tag, "_gap_load"}, int'(dl_load), 0);
      @(negedge clk); #1;
      check({tag, "_restart_load"}, int'(dl_load), 1);
      check({tag, "_restart_busy"}, int'(busy), 1);
      start = 1'b0;
      wait_done({tag, "_second"});
      check({tag, "_second_tap_out"}, int'(tap_out), int'(tap_out));
    end
    @(negedge clk); #1;
    check({tag, "_done_once"}, n_done, hold ? 2 : 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_fail"},  int'(fail), 0);
    check({tag, "_load"},  int'(dl_load), 0);
    check({tag, "_move"},  int'(dl_move), 0);
    check({tag, "_clr"},   int'(em_clear), 0);
    check({tag, "_dir"},   int'(dl_dir), 1);
    check({tag, "_tap"},   int'(tap_out), 0);
    check({tag, "_ws"},    int'(win_start), 0);
    check({tag, "_wl"},    int'(win_len), 0);
  endtask

  initial begin
    bit hit;
    start = 1'b0; dl_oor = 1'b0; em_early = 1'b0; em_late = 1'b0;
    clear_map();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_state("rst");
    rst_n = 1'b1;

    clear_map(); set_win(40, 20);
    run("win40", 1'b0);

    clear_map(); set_win(10, 5); set_win(30, 5);
    run("tie", 1'b0);

    clear_map();
    run("allfail", 1'b0);

    clear_map(); set_win(5, 30);
    clear_counts();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk); #1;
      if (dl_tap == 20) hit = 1'b1;
    end
    check("reach_tap20", int'(hit), 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_reset_state("midrst");
    clear_counts();
    repeat (3) @(negedge clk);
    #1;
    check("midrst_pulses", n_load + n_inc + n_dec + n_clr + n_done, 0);
    rst_n = 1'b1;
    run("postrst", 1'b0);

    clear_map(); set_win(80, 21); oor_tap = 90;
    run("oor", 1'b0);

    clear_map(); set_win(60, 7);
    run("hold", 1'b1);

    for (int k = 0; k < 6; k++) begin
      int nw;
      clear_map();
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) set_win($urandom_range(0, 125), $urandom_range(1, 30));
      if ($urandom_range(0, 2) == 0) oor_tap = $urandom_range(20, 127);
      run($sformatf("rnd%0d", k), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
